// File: rtl/window_loader_pkg.sv
// Shared types and helpers for the window loader and its bench.
// Holds nucleotide codes, loader states and the window stride.
package lsh_pkg;

  typedef logic [1:0] nucleotide_t;

  localparam nucleotide_t NUC_A = 2'b00;
  localparam nucleotide_t NUC_C = 2'b01;
  localparam nucleotide_t NUC_G = 2'b10;
  localparam nucleotide_t NUC_T = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HASH_RST,
    ST_HASH_WAIT,
    ST_COMMIT,
    ST_FINISH
  } loader_state_t;

  // Consecutive windows share KMER_SIZE-1 nucleotides.
  function automatic int stride(input int window_size, input int kmer_size);
    return window_size - kmer_size + 1;
  endfunction

endpackage

// File: rtl/window_loader_if.sv
// Stream, hasher handshake and commit signals of the window loader.
// The master modport is the loader side; slave is its environment.
interface window_loader_if
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE = 128
) ();

  logic        start;
  logic        is_reference;
  logic        nuc_valid;
  nucleotide_t nuc_data;
  logic        nuc_last;
  logic        nuc_ready;
  logic        hashing_is_done;
  nucleotide_t window [0:WINDOW_SIZE-1];
  logic [31:0] window_id;
  logic        reset_window_hasher;
  logic        ready_for_hashing;
  logic        is_insert;
  logic        is_query;
  logic        calculate_matched_window;
  logic        load_done;
  logic        window_overflow;

  modport master (
    input  start, is_reference, nuc_valid, nuc_data, nuc_last, hashing_is_done,
    output nuc_ready, window, window_id, reset_window_hasher, ready_for_hashing,
           is_insert, is_query, calculate_matched_window, load_done, window_overflow
  );

  modport slave (
    output start, is_reference, nuc_valid, nuc_data, nuc_last, hashing_is_done,
    input  nuc_ready, window, window_id, reset_window_hasher, ready_for_hashing,
           is_insert, is_query, calculate_matched_window, load_done, window_overflow
  );

endinterface

// File: rtl/window_loader_shift_reg.sv
// Window storage: WINDOW_SIZE nucleotides, newest enters at the top index,
// index 0 holds the oldest. Synchronous clear wins over shift.
module window_shift_reg
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE = 128
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        shift_en,
  input  nucleotide_t shift_in,
  output nucleotide_t window [0:WINDOW_SIZE-1]
);

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        window[i] <= NUC_A;
      end
    end else if (shift_en) begin
      for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
        window[i] <= window[i + 1];
      end
      window[WINDOW_SIZE - 1] <= shift_in;
    end
  end

endmodule

// File: rtl/window_loader.sv
// Slices a 2-bit nucleotide stream into overlapping windows and sequences
// the window hasher handshake plus insert/query commits for each window.
module window_loader
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE              = 128,
  parameter int KMER_SIZE                = 16,
  parameter int MAX_WINDOWS_IN_REFERENCE = 512,
  parameter int MAX_WINDOWS_IN_READ      = 16
) (
  input  logic            clk,
  input  logic            reset_window_loader,
  window_loader_if.master bus
);

  localparam int CNT_W = $clog2(WINDOW_SIZE + 1);
  localparam logic [CNT_W-1:0] NEED_FULL   = CNT_W'(WINDOW_SIZE);
  localparam logic [CNT_W-1:0] NEED_STRIDE = CNT_W'(stride(WINDOW_SIZE, KMER_SIZE));
  localparam logic [31:0] CAP_REF  = 32'(MAX_WINDOWS_IN_REFERENCE);
  localparam logic [31:0] CAP_READ = 32'(MAX_WINDOWS_IN_READ);

  loader_state_t    state;
  logic             mode_ref;
  logic             last_seen;
  logic             skip_window;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] need;
  logic [31:0]      window_id_q;
  logic             nuc_ready_q;
  logic             reset_hasher_q;
  logic             ready_hash_q;
  logic             insert_q;
  logic             query_q;
  logic             calc_q;
  logic             load_done_q;
  logic             overflow_q;

  logic             accept;
  logic [CNT_W-1:0] fill_next;
  logic             at_capacity;
  nucleotide_t      win_q [0:WINDOW_SIZE-1];

  assign accept      = (state == ST_FILL) && bus.nuc_valid;
  assign fill_next   = fill_cnt + CNT_W'(1);
  assign at_capacity = window_id_q >= (mode_ref ? CAP_REF : CAP_READ);

  window_shift_reg #(.WINDOW_SIZE(WINDOW_SIZE)) u_shift (
    .clk      (clk),
    .clear    (reset_window_loader),
    .shift_en (accept),
    .shift_in (bus.nuc_data),
    .window   (win_q)
  );

  // Capacity is decided on the completing beat so the hasher reset pulse
  // can be registered; a skipped window still walks through COMMIT silently.
  always_ff @(posedge clk) begin
    if (reset_window_loader) begin
      state          <= ST_IDLE;
      mode_ref       <= 1'b0;
      last_seen      <= 1'b0;
      skip_window    <= 1'b0;
      fill_cnt       <= '0;
      need           <= NEED_FULL;
      window_id_q    <= '0;
      nuc_ready_q    <= 1'b0;
      reset_hasher_q <= 1'b0;
      ready_hash_q   <= 1'b0;
      insert_q       <= 1'b0;
      query_q        <= 1'b0;
      calc_q         <= 1'b0;
      load_done_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      reset_hasher_q <= 1'b0;
      insert_q       <= 1'b0;
      query_q        <= 1'b0;
      calc_q         <= 1'b0;
      load_done_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_ref    <= bus.is_reference;
            window_id_q <= '0;
            fill_cnt    <= '0;
            need        <= NEED_FULL;
            last_seen   <= 1'b0;
            overflow_q  <= 1'b0;
            nuc_ready_q <= 1'b1;
            state       <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (accept) begin
            fill_cnt <= fill_next;
            if (fill_next == need) begin
              last_seen   <= bus.nuc_last;
              nuc_ready_q <= 1'b0;
              state       <= ST_HASH_RST;
              if (at_capacity) begin
                skip_window <= 1'b1;
                overflow_q  <= 1'b1;
              end else begin
                skip_window    <= 1'b0;
                reset_hasher_q <= 1'b1;
              end
            end else if (bus.nuc_last) begin
              nuc_ready_q <= 1'b0;
              load_done_q <= 1'b1;
              calc_q      <= ~mode_ref;
              state       <= ST_FINISH;
            end
          end
        end
        ST_HASH_RST: begin
          if (skip_window) begin
            state <= ST_COMMIT;
          end else begin
            ready_hash_q <= 1'b1;
            state        <= ST_HASH_WAIT;
          end
        end
        ST_HASH_WAIT: begin
          if (bus.hashing_is_done) begin
            ready_hash_q <= 1'b0;
            insert_q     <= mode_ref;
            query_q      <= ~mode_ref;
            state        <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (!skip_window) begin
            window_id_q <= window_id_q + 32'd1;
          end
          fill_cnt <= '0;
          need     <= NEED_STRIDE;
          if (last_seen) begin
            load_done_q <= 1'b1;
            calc_q      <= ~mode_ref;
            state       <= ST_FINISH;
          end else begin
            nuc_ready_q <= 1'b1;
            state       <= ST_FILL;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.window                   = win_q;
  assign bus.window_id                = window_id_q;
  assign bus.nuc_ready                = nuc_ready_q;
  assign bus.reset_window_hasher      = reset_hasher_q;
  assign bus.ready_for_hashing        = ready_hash_q;
  assign bus.is_insert                = insert_q;
  assign bus.is_query                 = query_q;
  assign bus.calculate_matched_window = calc_q;
  assign bus.load_done                = load_done_q;
  assign bus.window_overflow          = overflow_q;

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader: streams generated nucleotide patterns,
// emulates the window hasher and checks pulses, ids and window contents.
module tb_window_loader;
  import lsh_pkg::*;

  localparam int WS       = 128;
  localparam int KS       = 16;
  localparam int MAX_REF  = 512;
  localparam int MAX_READ = 16;
  localparam int STEP     = stride(WS, KS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_loader_if #(.WINDOW_SIZE(WS)) bus ();

  window_loader #(
    .WINDOW_SIZE              (WS),
    .KMER_SIZE                (KS),
    .MAX_WINDOWS_IN_REFERENCE (MAX_REF),
    .MAX_WINDOWS_IN_READ      (MAX_READ)
  ) dut (
    .clk                 (clk),
    .reset_window_loader (rst),
    .bus                 (bus.master)
  );

  int checks = 0;
  int errors = 0;

  int rwh_cnt = 0, rfh_cycles = 0, ins_cnt = 0, qry_cnt = 0;
  int calc_cnt = 0, done_cnt = 0, together_cnt = 0, commit_cnt = 0;
  logic [31:0] commit_id [0:63];
  nucleotide_t commit_w0 [0:63];
  nucleotide_t commit_wl [0:63];

  bit auto_done  = 1'b1;
  int done_delay = 3;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic nucleotide_t nuc_of(input int i);
    return nucleotide_t'((i * 5 + i / 3) % 4);
  endfunction

  // Observes every cycle away from the clock edge.
  always @(negedge clk) begin
    if (bus.reset_window_hasher) rwh_cnt++;
    if (bus.ready_for_hashing) rfh_cycles++;
    if (bus.is_insert) ins_cnt++;
    if (bus.is_query) qry_cnt++;
    if (bus.is_insert || bus.is_query) begin
      if (commit_cnt < 64) begin
        commit_id[commit_cnt] = bus.window_id;
        commit_w0[commit_cnt] = bus.window[0];
        commit_wl[commit_cnt] = bus.window[WS-1];
      end
      commit_cnt++;
    end
    if (bus.load_done) done_cnt++;
    if (bus.calculate_matched_window) calc_cnt++;
    if (bus.load_done && bus.calculate_matched_window) together_cnt++;
  end

  // Hasher model: raises done for one cycle done_delay cycles after ready.
  initial begin
    bus.hashing_is_done = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_done && bus.ready_for_hashing) begin
        repeat (done_delay) @(posedge clk);
        #1 bus.hashing_is_done = 1'b1;
        @(posedge clk);
        #1 bus.hashing_is_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_stimulus(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int budget = 0;
      bus.nuc_valid = 1'b1;
      bus.nuc_data  = nuc_of(i);
      bus.nuc_last  = (i == n - 1);
      @(negedge clk);
      while (!bus.nuc_ready && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.nuc_ready) begin
        check_output("beat_timeout", i, n);
        bus.nuc_valid = 1'b0;
        bus.nuc_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      bus.nuc_valid = 1'b0;
      bus.nuc_last  = 1'b0;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start(input bit ref_mode);
    bus.start        = 1'b1;
    bus.is_reference = ref_mode;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.is_reference = 1'b0;
  endtask

  task automatic wait_load_done(input int base);
    int b = 0;
    while (done_cnt == base && b < 5000) begin
      @(negedge clk);
      b++;
    end
    if (done_cnt == base) check_output("load_done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    int nonzero = 0;
    for (int i = 0; i < WS; i++) begin
      if (bus.window[i] !== NUC_A) nonzero++;
    end
    check_output({tag, "_nuc_ready"}, bus.nuc_ready, 0);
    check_output({tag, "_rwh"}, bus.reset_window_hasher, 0);
    check_output({tag, "_rfh"}, bus.ready_for_hashing, 0);
    check_output({tag, "_insert"}, bus.is_insert, 0);
    check_output({tag, "_query"}, bus.is_query, 0);
    check_output({tag, "_calc"}, bus.calculate_matched_window, 0);
    check_output({tag, "_load_done"}, bus.load_done, 0);
    check_output({tag, "_overflow"}, bus.window_overflow, 0);
    check_output({tag, "_window_id"}, bus.window_id, 0);
    check_output({tag, "_window_nonzero"}, nonzero, 0);
  endtask

  initial begin
    int b_ins, b_qry, b_rwh, b_rfh, b_calc, b_done, b_tog, b_com;
    int bad, budget;
    nucleotide_t snap [0:WS-1];

    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.is_reference = 1'b0;
    bus.nuc_valid    = 1'b0;
    bus.nuc_data     = NUC_A;
    bus.nuc_last     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reference stream of 241: two windows, second starts at input 113.
    b_ins = ins_cnt; b_qry = qry_cnt; b_rwh = rwh_cnt; b_calc = calc_cnt;
    b_done = done_cnt; b_com = commit_cnt;
    done_delay = 3;
    pulse_start(1'b1);
    apply_stimulus(241, 1'b0);
    wait_load_done(b_done);
    check_output("ref_inserts", ins_cnt - b_ins, 2);
    check_output("ref_queries", qry_cnt - b_qry, 0);
    check_output("ref_hasher_resets", rwh_cnt - b_rwh, 2);
    check_output("ref_id0", commit_id[b_com], 0);
    check_output("ref_id1", commit_id[b_com+1], 1);
    check_output("ref_w0_first", commit_w0[b_com], nuc_of(0));
    check_output("ref_w0_last", commit_wl[b_com], nuc_of(WS-1));
    check_output("ref_w1_first", commit_w0[b_com+1], nuc_of(STEP));
    check_output("ref_w1_last", commit_wl[b_com+1], nuc_of(240));
    check_output("ref_load_done", done_cnt - b_done, 1);
    check_output("ref_calc", calc_cnt - b_calc, 0);

    // Read stream of 127: too short for any window.
    b_rwh = rwh_cnt; b_rfh = rfh_cycles; b_qry = qry_cnt; b_done = done_cnt;
    b_tog = together_cnt; b_calc = calc_cnt;
    pulse_start(1'b0);
    apply_stimulus(127, 1'b0);
    wait_load_done(b_done);
    check_output("short_rwh", rwh_cnt - b_rwh, 0);
    check_output("short_rfh", rfh_cycles - b_rfh, 0);
    check_output("short_query", qry_cnt - b_qry, 0);
    check_output("short_load_done", done_cnt - b_done, 1);
    check_output("short_calc_with_done", together_cnt - b_tog, 1);
    check_output("short_calc", calc_cnt - b_calc, 1);
    check_output("short_window_id", bus.window_id, 0);

    // Read stream of 1936: 17 windows against a capacity of 16.
    b_ins = ins_cnt; b_qry = qry_cnt; b_calc = calc_cnt; b_done = done_cnt;
    b_com = commit_cnt;
    pulse_start(1'b0);
    apply_stimulus(WS + 16 * STEP, 1'b0);
    wait_load_done(b_done);
    check_output("ovf_queries", qry_cnt - b_qry, MAX_READ);
    check_output("ovf_inserts", ins_cnt - b_ins, 0);
    bad = 0;
    for (int k = 0; k < MAX_READ; k++) begin
      if (commit_id[b_com+k] !== 32'(k)) bad++;
    end
    check_output("ovf_id_sequence_bad", bad, 0);
    check_output("ovf_flag", bus.window_overflow, 1);
    check_output("ovf_calc", calc_cnt - b_calc, 1);
    check_output("ovf_load_done", done_cnt - b_done, 1);

    // Gapped reference stream with a slow hasher: cycle-exact handshake.
    b_ins = ins_cnt; b_done = done_cnt;
    done_delay = 10;
    pulse_start(1'b1);
    check_output("gap_overflow_cleared", bus.window_overflow, 0);
    fork
      apply_stimulus(241, 1'b1);
      begin
        budget = 0;
        @(negedge clk);
        while (!bus.reset_window_hasher && budget < 1000) begin
          @(negedge clk);
          budget++;
        end
        check_output("gap_rwh_seen", bus.reset_window_hasher, 1);
        check_output("gap_rfh_during_rwh", bus.ready_for_hashing, 0);
        check_output("gap_ready_during_rwh", bus.nuc_ready, 0);
        @(negedge clk);
        check_output("gap_rfh_first", bus.ready_for_hashing, 1);
        check_output("gap_ready_first", bus.nuc_ready, 0);
        bad = 0;
        for (int i = 0; i < WS; i++) begin
          snap[i] = bus.window[i];
          if (bus.window[i] !== nuc_of(i)) bad++;
        end
        check_output("gap_window_content_bad", bad, 0);
        bad = 0;
        for (int k = 1; k < 10; k++) begin
          @(negedge clk);
          if (bus.ready_for_hashing !== 1'b1 || bus.nuc_ready !== 1'b0 || bus.is_insert !== 1'b0) bad++;
          for (int i = 0; i < WS; i++) begin
            if (bus.window[i] !== snap[i]) bad++;
          end
        end
        check_output("gap_hold_stable_bad", bad, 0);
        @(negedge clk);
        check_output("gap_rfh_at_done", bus.ready_for_hashing, 1);
        check_output("gap_ready_at_done", bus.nuc_ready, 0);
        @(negedge clk);
        check_output("gap_commit_pulse", bus.is_insert, 1);
        check_output("gap_rfh_at_commit", bus.ready_for_hashing, 0);
        check_output("gap_ready_at_commit", bus.nuc_ready, 0);
        @(negedge clk);
        check_output("gap_ready_return", bus.nuc_ready, 1);
        check_output("gap_commit_single", bus.is_insert, 0);
      end
    join
    wait_load_done(b_done);
    check_output("gap_inserts", ins_cnt - b_ins, 2);

    // Reset while waiting on the hasher aborts without a commit.
    b_ins = ins_cnt;
    auto_done  = 1'b0;
    done_delay = 3;
    pulse_start(1'b1);
    apply_stimulus(WS, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_output("abort_in_hash_wait", bus.ready_for_hashing, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("abort");
    rst = 1'b0;
    check_output("abort_no_insert", ins_cnt - b_ins, 0);
    auto_done = 1'b1;
    b_qry = qry_cnt; b_ins = ins_cnt; b_done = done_cnt; b_com = commit_cnt;
    pulse_start(1'b0);
    apply_stimulus(WS, 1'b0);
    wait_load_done(b_done);
    check_output("restart_queries", qry_cnt - b_qry, 1);
    check_output("restart_inserts", ins_cnt - b_ins, 0);
    check_output("restart_id", commit_id[b_com], 0);

    // start pulsed mid-fill with the other mode must be ignored.
    b_qry = qry_cnt; b_ins = ins_cnt; b_done = done_cnt; b_com = commit_cnt;
    b_calc = calc_cnt;
    pulse_start(1'b0);
    fork
      apply_stimulus(WS, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1;
        bus.start        = 1'b1;
        bus.is_reference = 1'b1;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.is_reference = 1'b0;
      end
    join
    wait_load_done(b_done);
    check_output("midstart_queries", qry_cnt - b_qry, 1);
    check_output("midstart_inserts", ins_cnt - b_ins, 0);
    check_output("midstart_id", commit_id[b_com], 0);
    check_output("midstart_calc", calc_cnt - b_calc, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_loader.md
Name: window_loader

Overview:
Hardware replacement for the bench-side window slicing that sits directly upstream of window_hasher. It accepts a 2-bit nucleotide stream and builds overlapping windows of WINDOW_SIZE nucleotides at a stride of WINDOW_SIZE-KMER_SIZE+1. For each window it sequences reset_window_hasher, ready_for_hashing and hashing_is_done, then pulses is_insert in reference mode or is_query in read mode toward hash_table/stats. At the end of a read stream it pulses calculate_matched_window.

Parameters:
WINDOW_SIZE, 128, nucleotides per window.
KMER_SIZE, 16, k-mer length; overlap between consecutive windows is KMER_SIZE-1.
MAX_WINDOWS_IN_REFERENCE, 512, window capacity in reference mode.
MAX_WINDOWS_IN_READ, 16, window capacity in read mode.

Ports:
clk  in  1  single clock, rising edge.
reset_window_loader  in  1  synchronous, active-high reset.
start  in  1  one-cycle start pulse; sampled only in IDLE.
is_reference  in  1  mode, sampled with start: 1 = reference/insert, 0 = read/query.
nuc_valid  in  1  stream beat valid.
nuc_data  in  2  nucleotide code: A=00, C=01, G=10, T=11.
nuc_last  in  1  final beat of the stream; qualified by nuc_valid.
nuc_ready  out  1  loader accepts a beat this cycle.
hashing_is_done  in  1  from window_hasher.
window  out  2 x [0:WINDOW_SIZE-1]  current window; window[0] is the oldest nucleotide.
window_id  out  32  index of the current window; 0 at each start.
reset_window_hasher  out  1  one-cycle pulse before each window.
ready_for_hashing  out  1  window valid, held until done.
is_insert  out  1  one-cycle commit pulse, reference mode.
is_query  out  1  one-cycle commit pulse, read mode.
calculate_matched_window  out  1  one-cycle pulse at end of read-mode stream.
load_done  out  1  one-cycle pulse when the stream is fully processed.
window_overflow  out  1  sticky; window count exceeded capacity; cleared by start.

Behaviour:
- Reset: state IDLE; window all 00; window_id 0; all pulse, strobe and flag outputs 0; nuc_ready 0. Reset in any state, including HASH_WAIT, aborts the operation. The partial window is lost and no commit pulse is issued.
- States: IDLE, FILL, HASH_RST, HASH_WAIT, COMMIT, FINISH.
- IDLE: nuc_ready=0. On start, latch mode, clear window_id, fill_cnt and window_overflow, set need=WINDOW_SIZE, and go to FILL. start in any other state is ignored.
- FILL: nuc_ready=1. Each accepted beat (nuc_valid & nuc_ready) shifts nuc_data into window[WINDOW_SIZE-1]; all other entries move down by one; fill_cnt increments.
  - fill_cnt reaches need on the accepted beat: go to HASH_RST and record last_seen=nuc_last.
  - nuc_last accepted before need is reached: the partial window is discarded with no hash and no commit; go to FINISH.
- HASH_RST: nuc_ready=0; reset_window_hasher=1 for exactly this cycle. Next state is HASH_WAIT, or COMMIT-skip if over capacity (see below).
- HASH_WAIT: ready_for_hashing=1 and window held stable. The first cycle with hashing_is_done=1 moves to COMMIT. hashing_is_done is ignored in every other state.
- COMMIT: ready_for_hashing=0; exactly one of is_insert/is_query is 1 for this cycle, per the latched mode.
  - Next cycle: window_id increments, fill_cnt clears, need=WINDOW_SIZE-KMER_SIZE+1 (stride).
  - Go to FINISH if last_seen, else FILL. The retained KMER_SIZE-1 entries form the overlap.
- Capacity: if window_id equals the mode's MAX in HASH_RST, no reset/ready/commit is issued for that window, window_overflow is set, and the state advances as if committed. Remaining beats are still consumed.
- FINISH: load_done=1 for one cycle. In read mode calculate_matched_window=1 in the same cycle, even if zero windows were formed. Then go to IDLE.
- Latency: the final beat of a window is accepted at cycle t. reset_window_hasher is high at t+1 and ready_for_hashing is high from t+2. If done is seen at cycle d, the commit pulse is at d+1 and nuc_ready returns at d+2.
- window_id is 32-bit unsigned and never wraps in practice; capacity limits apply before any wrap.

Decomposition:
- Package lsh_pkg: nucleotide_t (2-bit), NUC_A/C/G/T constants, loader state enum, and a stride function (WINDOW_SIZE-KMER_SIZE+1) shared with the bench.
- One sub-module, window_shift_reg: WINDOW_SIZE x 2-bit shift register with a shift enable and a synchronous clear.

Test Plan:
- Reference stream of 241 nucleotides, done returned 3 cycles after ready -> two is_insert pulses with window_id 0 then 1; second window[0] equals input index 113; load_done once; no calculate_matched_window.
- Read stream of 127 nucleotides -> no reset_window_hasher/ready/query; load_done and calculate_matched_window pulse together; window_id stays 0.
- Read stream of 1936 nucleotides (17 windows) -> 16 is_query pulses (ids 0..15), window_overflow=1, all beats consumed, calculate_matched_window once.
- nuc_valid gapped every other cycle, hashing_is_done held 0 for 10 cycles -> ready_for_hashing and window stable throughout; nuc_ready=0 until 2 cycles after done.
- reset_window_loader asserted in HASH_WAIT -> next cycle all outputs 0 and IDLE; a following start with a 128-nucleotide stream yields one commit with id 0.
- start pulsed during FILL -> ignored; mode and window_id unchanged.
